bfp_decomp_arb: RTL and testbench

BFP_DECOMP_ARB -- requirements
Module: bfp_decomp_arb

---
 rtl/bfp_decomp_arb.sv | 122 ++++++++++++
 tb/tb_bfp_decomp_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_decomp_arb.sv
// bfp_decomp_arb: round-robin packet arbiter feeding N AXIS requesters into one decompression engine
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_axis_*              : per-port requester streams (port p in slice p), tready per port
//   m_axis_*              : stream to the shared engine, combinationally muxed from the granted port
//   cfg_*                 : per-port engine configuration, sampled only when a port is granted
//   ctrl_*                : configuration currently applied to the engine
//   grant_id, busy        : current/last granted port, high while passing or draining
module bfp_decomp_arb #(
    parameter int N_PORTS      = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_PORTS*64-1:0]         s_axis_tdata,
    input  logic [N_PORTS*8-1:0]          s_axis_tkeep,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    input  logic [N_PORTS*32-1:0]         s_axis_tuser,
    output logic [N_PORTS-1:0]            s_axis_tready,
    output logic [63:0]                   m_axis_tdata,
    output logic [7:0]                    m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [31:0]                   m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic [N_PORTS*4-1:0]          cfg_ud_comp_meth,
    input  logic [N_PORTS*4-1:0]          cfg_ud_iq_width,
    input  logic [N_PORTS*4-1:0]          cfg_fs_offset,
    output logic [3:0]                    ctrl_ud_comp_meth,
    output logic [3:0]                    ctrl_ud_iq_width,
    output logic [3:0]                    ctrl_fs_offset,
    output logic [$clog2(N_PORTS)-1:0]    grant_id,
    output logic                          busy
);
    localparam int GW = $clog2(N_PORTS);
    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
    state_t        state_q;
    logic [GW-1:0] grant_q, sel, idx;
    logic          sel_vld, pass, xfer_last, busy_q;
    logic [3:0]    meth_q, iq_q, fs_q;
    logic [7:0]    cnt_q;
    logic [63:0]   td [N_PORTS];
    logic [7:0]    tk [N_PORTS];
    logic [31:0]   tu [N_PORTS];
    logic [3:0]    cm [N_PORTS];
    logic [3:0]    ci [N_PORTS];
    logic [3:0]    cf [N_PORTS];
    genvar g;
    generate
        for (g = 0; g < N_PORTS; g++) begin : g_port
            assign td[g] = s_axis_tdata[g*64 +: 64];
            assign tk[g] = s_axis_tkeep[g*8 +: 8];
            assign tu[g] = s_axis_tuser[g*32 +: 32];
            assign cm[g] = cfg_ud_comp_meth[g*4 +: 4];
            assign ci[g] = cfg_ud_iq_width[g*4 +: 4];
            assign cf[g] = cfg_fs_offset[g*4 +: 4];
        end
    endgenerate
    // round-robin scan starting one past the last grant, wrapping at N_PORTS
    always_comb begin
        sel     = grant_q;
        sel_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = GW'((int'(grant_q) + i) % N_PORTS);
            if (!sel_vld && s_axis_tvalid[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end
    assign pass      = state_q == PASS;
    assign xfer_last = pass && s_axis_tvalid[grant_q] && s_axis_tlast[grant_q] && m_axis_tready;
    always_comb begin
        m_axis_tvalid = pass && s_axis_tvalid[grant_q];
        m_axis_tlast  = pass && s_axis_tlast[grant_q];
        m_axis_tdata  = pass ? td[grant_q] : '0;
        m_axis_tkeep  = pass ? tk[grant_q] : '0;
        m_axis_tuser  = pass ? tu[grant_q] : '0;
        s_axis_tready = '0;
        for (int p = 0; p < N_PORTS; p++)
            s_axis_tready[p] = pass && grant_q == GW'(p) && m_axis_tready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= GW'(N_PORTS - 1);
            meth_q  <= '0;
            iq_q    <= '0;
            fs_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (sel_vld) begin
                    state_q <= PASS;
                    grant_q <= sel;
                    meth_q  <= cm[sel];
                    iq_q    <= ci[sel];
                    fs_q    <= cf[sel];
                    busy_q  <= 1'b1;
                end
                PASS: if (xfer_last) begin
                    state_q <= DRAIN_CYCLES > 0 ? DRAIN : IDLE;
                    busy_q  <= DRAIN_CYCLES > 0;
                    cnt_q   <= 8'(DRAIN_CYCLES - 1);
                end
                DRAIN: begin
                    state_q <= cnt_q == 8'd0 ? IDLE : DRAIN;
                    busy_q  <= cnt_q != 8'd0;
                    cnt_q   <= cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ctrl_ud_comp_meth = meth_q;
    assign ctrl_ud_iq_width  = iq_q;
    assign ctrl_fs_offset    = fs_q;
    assign grant_id          = grant_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_bfp_decomp_arb.sv
// tb_bfp_decomp_arb: directed bench with a packet-level arbitration model checked every cycle
module tb_bfp_decomp_arb;
    localparam int N = 4;
    localparam int D = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*64-1:0] s_tdata;
    logic [N*8-1:0]  s_tkeep;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [N*32-1:0] s_tuser;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tvalid, m_tlast, m_tready;
    logic [31:0]     m_tuser;
    logic [N*4-1:0]  cfg_m, cfg_i, cfg_f;
    logic [3:0]      c_m, c_i, c_f;
    logic [1:0]      gid;
    logic            busy;
    logic [N*64-1:0] s1_tdata;
    logic [N-1:0]    s1_tvalid, s1_tlast, s1_tready;
    logic [63:0]     m1_tdata;
    logic [7:0]      m1_tkeep;
    logic            m1_tvalid, m1_tlast, m1_tready;
    logic [31:0]     m1_tuser;
    logic [3:0]      c1_m, c1_i, c1_f;
    logic [1:0]      g1;
    logic            busy1;

    bfp_decomp_arb #(.N_PORTS(N), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .cfg_ud_comp_meth(cfg_m), .cfg_ud_iq_width(cfg_i), .cfg_fs_offset(cfg_f),
        .ctrl_ud_comp_meth(c_m), .ctrl_ud_iq_width(c_i), .ctrl_fs_offset(c_f),
        .grant_id(gid), .busy(busy)
    );
    bfp_decomp_arb #(.N_PORTS(N), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s1_tdata), .s_axis_tkeep('0), .s_axis_tvalid(s1_tvalid),
        .s_axis_tlast(s1_tlast), .s_axis_tuser('0), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
        .m_axis_tlast(m1_tlast), .m_axis_tuser(m1_tuser), .m_axis_tready(m1_tready),
        .cfg_ud_comp_meth('0), .cfg_ud_iq_width('0), .cfg_fs_offset('0),
        .ctrl_ud_comp_meth(c1_m), .ctrl_ud_iq_width(c1_i), .ctrl_fs_offset(c1_f),
        .grant_id(g1), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic [31:0] u;} beat_t;
    beat_t q [N][$];
    logic [N-1:0] en, hs;
    logic tog;
    int checks = 0, errors = 0;
    int gport = -1, last = N - 1, dl = 0, mp, dcnt;
    logic [3:0] em = 0, ei = 0, ef = 0, last_iq;
    logic ev, in_pkt = 0, counting = 0;
    logic [104:0] eb;
    logic [N-1:0] er;
    logic [63:0] log_d [$];
    logic log_l [$];
    int log_p [$];
    int first_port [$];
    logic [11:0] first_ctrl [$];
    int drain_len [$];

    function automatic logic [63:0] mk(int p, int k, int b);
        return (64'(p) << 56) | (64'(k) << 48) | 64'(b);
    endfunction

    task automatic chk(string n, logic [127:0] a, logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (en[p] && q[p].size() > 0) begin
                s_tvalid[p] = 1'b1;
                s_tdata[p*64 +: 64] = q[p][0].d;
                s_tkeep[p*8 +: 8] = q[p][0].k;
                s_tlast[p] = q[p][0].l;
                s_tuser[p*32 +: 32] = q[p][0].u;
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[p*64 +: 64] = mk(p, 255, 255);
                s_tkeep[p*8 +: 8] = 8'h5A;
                s_tlast[p] = 1'b1;
                s_tuser[p*32 +: 32] = 32'hDEAD0000 | 32'(p);
            end
        end
    endtask

    task automatic push(int p, int k, int n);
        for (int b = 0; b < n; b++)
            q[p].push_back('{mk(p, k, b), 8'(8'hFF >> (b % 8)), b == n - 1, 32'(p*256 + k*16 + b)});
    endtask

    function automatic bit q_empty();
        for (int p = 0; p < N; p++) if (q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        log_d.delete(); log_l.delete(); log_p.delete();
        first_port.delete(); first_ctrl.delete(); drain_len.delete();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #2;
            if (gport < 0 && dl == 0 && q_empty()) begin
                repeat (2) begin @(posedge clk); #2; end
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_idle timeout");
    endtask

    task automatic wait_beats(int n);
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #2;
            if (log_d.size() >= n) return;
        end
        checks++; errors++;
        $display("FAIL wait_beats timeout");
    endtask

    // source side: retire a beat once the previous edge saw its handshake
    initial forever begin
        @(posedge clk); #1;
        for (int p = 0; p < N; p++) if (hs[p] && q[p].size() > 0) void'(q[p].pop_front());
        if (tog) m_tready = ~m_tready;
        drive();
    end

    // per-cycle compare against the arbitration model, then advance the model
    initial forever begin
        @(negedge clk);
        hs = s_tvalid & s_tready;
        if (!rst_n) begin
            chk("rst_mvalid", m_tvalid, 0);
            chk("rst_sready", s_tready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", gid, N - 1);
            chk("rst_ctrl", {c_m, c_i, c_f}, 0);
            gport = -1; last = N - 1; dl = 0; em = 0; ei = 0; ef = 0;
            in_pkt = 0; counting = 0;
        end else begin
            ev = 0; eb = '0; er = '0;
            if (gport >= 0) begin
                ev = s_tvalid[gport];
                eb = {s_tdata[gport*64 +: 64], s_tkeep[gport*8 +: 8], s_tlast[gport], s_tuser[gport*32 +: 32]};
                er[gport] = m_tready;
            end
            chk("m_tvalid", m_tvalid, ev);
            chk("m_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, eb);
            chk("s_tready", s_tready, er);
            chk("grant_id", gid, last);
            chk("ctrl", {c_m, c_i, c_f}, {em, ei, ef});
            chk("busy", busy, gport >= 0 || dl > 0);
            if (counting) begin
                if (!busy) begin drain_len.push_back(dcnt); counting = 0; end
                else if (!m_tvalid) dcnt++;
            end
            if (m_tvalid && m_tready) begin
                if (!in_pkt) begin first_port.push_back(gid); first_ctrl.push_back({c_m, c_i, c_f}); end
                log_d.push_back(m_tdata); log_l.push_back(m_tlast); log_p.push_back(gid);
                in_pkt = !m_tlast;
                if (m_tlast) begin last_iq = c_i; counting = 1; dcnt = 0; end
            end
            if (gport >= 0) begin
                if (s_tvalid[gport] && s_tlast[gport] && m_tready) begin gport = -1; dl = D; end
            end else if (dl > 0) begin
                dl--;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    mp = (last + i) % N;
                    if (s_tvalid[mp]) begin
                        gport = mp; last = mp;
                        em = cfg_m[mp*4 +: 4]; ei = cfg_i[mp*4 +: 4]; ef = cfg_f[mp*4 +: 4];
                        break;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    int b1 [2];
    int t0l, t1f, nb, fp;
    logic [1:0] h1;
    logic [3:0] la;

    task automatic drive1();
        s1_tvalid = '0; s1_tlast = '0; s1_tdata = '0;
        for (int p = 0; p < 2; p++) begin
            s1_tvalid[p] = b1[p] < 2;
            s1_tlast[p] = b1[p] == 1;
            s1_tdata[p*64 +: 64] = mk(p, 9, b1[p]);
        end
    endtask

    initial begin
        en = '1; tog = 0; m_tready = 1; hs = '0;
        cfg_m = '0; cfg_i = '0; cfg_f = '0;
        b1 = '{2, 2}; drive1(); m1_tready = 1;
        drive();
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // single port, 6-beat packet, then drain
        @(posedge clk); #2;
        cfg_m[3:0] = 1; cfg_i[3:0] = 9; cfg_f[3:0] = 0;
        clear_logs(); push(0, 1, 6); drive();
        wait_idle();
        chk("t1_beats", log_d.size(), 6);
        chk("t1_port", first_port[0], 0);
        chk("t1_ctrl", first_ctrl[0], 12'h190);
        chk("t1_beat6", {log_l[5], log_d[5]}, {1'b1, mk(0, 1, 5)});
        chk("t1_beat5_notlast", log_l[4], 0);
        chk("t1_drain", drain_len[0], 8);

        // all ports at once after reset: order 0..3, port 3 single-beat
        @(posedge clk); #2 rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
        for (int p = 0; p < N; p++) begin
            cfg_m[p*4 +: 4] = 4'(p + 1); cfg_i[p*4 +: 4] = 4'(8 + p); cfg_f[p*4 +: 4] = 4'(p);
        end
        clear_logs();
        push(0, 2, 3); push(1, 2, 3); push(2, 2, 3); push(3, 2, 1); drive();
        wait_idle();
        chk("t2_order", {4'(first_port[0]), 4'(first_port[1]), 4'(first_port[2]), 4'(first_port[3])}, 16'h0123);
        chk("t2_iq", {first_ctrl[0][7:4], first_ctrl[1][7:4], first_ctrl[2][7:4], first_ctrl[3][7:4]}, 16'h89AB);
        chk("t2_ctrl3", first_ctrl[3], 12'h4B3);
        chk("t2_beats", log_d.size(), 10);
        chk("t2_single", {log_l[9], log_d[9]}, {1'b1, mk(3, 2, 0)});
        chk("t2_drain", {8'(drain_len[0]), 8'(drain_len[1]), 8'(drain_len[2]), 8'(drain_len[3])}, 32'h08080808);

        // port 2 with engine ready toggling every cycle
        clear_logs(); push(2, 3, 5); tog = 1; drive();
        wait_idle();
        tog = 0; m_tready = 1;
        chk("t3_beats", log_d.size(), 5);
        for (int b = 0; b < 5; b++) chk("t3_beat", {32'(log_p[b]), log_d[b]}, {32'd2, mk(2, 3, b)});

        // cfg change mid-packet plus a valid bubble; regrant of the same port
        cfg_m[7:4] = 1; cfg_i[7:4] = 9; cfg_f[7:4] = 0;
        clear_logs(); push(1, 4, 4); drive();
        wait_beats(2);
        cfg_i[7:4] = 12; en[1] = 0; drive();
        repeat (2) begin @(posedge clk); #2; end
        en[1] = 1; drive();
        wait_idle();
        la = last_iq;
        push(1, 5, 2); drive();
        wait_idle();
        chk("t4_iq_end_a", la, 9);
        chk("t4_iq", {first_ctrl[0][7:4], first_ctrl[1][7:4]}, 8'h9C);
        chk("t4_regrant", first_port[1], 1);
        chk("t4_beats", log_d.size(), 6);

        // reset during beat 3 of a port-3 packet
        clear_logs(); push(3, 6, 5); drive();
        wait_beats(2);
        rst_n = 0; #1;
        chk("t5_rst_valid", m_tvalid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_grant", gid, 3);
        chk("t5_rst_ctrl", {c_m, c_i, c_f}, 0);
        chk("t5_rst_ready", s_tready, 0);
        for (int p = 0; p < N; p++) q[p].delete();
        drive();
        @(posedge clk); #2 rst_n = 1;
        clear_logs(); push(3, 7, 2); push(0, 8, 2); drive();
        wait_idle();
        chk("t5_order", {4'(first_port[0]), 4'(first_port[1])}, 8'h03);
        chk("t5_beats", log_d.size(), 4);
        chk("t5_first", log_d[0], mk(0, 8, 0));
        chk("t5_p3", log_d[2], mk(3, 7, 0));

        // zero-drain build: one selection cycle between packets
        b1 = '{0, 0}; drive1();
        t0l = -1; t1f = -1; nb = 0; fp = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m1_tvalid && m1_tready) begin
                nb++;
                if (fp < 0) fp = int'(g1);
                if (g1 == 2'd0 && m1_tlast) t0l = k;
                if (g1 == 2'd1 && t1f < 0) t1f = k;
            end
            h1 = s1_tvalid[1:0] & s1_tready[1:0];
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) if (h1[p]) b1[p]++;
            drive1();
        end
        chk("t6_gap", t1f - t0l, 2);
        chk("t6_beats", nb, 4);
        chk("t6_first", fp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
